// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths, the accumulator-drain
// FSM state encoding and the signed saturation helper used by requant stages.
package npu_pkg;

    localparam int ACC_WIDTH_DEF = 32;
    localparam int OUT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2,
        DONE    = 2'd3
    } drain_state_t;

    // Clamp a wide signed value into the range of a signed out_w-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/pe_requant.sv
// Combinational requantizer: round-half-up arithmetic right shift of a signed
// accumulator, then saturation to signed OUT_WIDTH. With PE_DRAIN_RELU_EN
// defined, negative saturated results are forced to zero.
module pe_requant
    import npu_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [ACC_WIDTH-1:0]   acc,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [OUT_WIDTH-1:0]   q
);

    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] half;
    logic signed [ACC_WIDTH:0] r;
    logic signed [63:0]        sat;

    // One extra bit of headroom keeps acc + rounding term from overflowing.
    always_comb begin
        ext  = {acc[ACC_WIDTH-1], acc};
        half = '0;
        if (shift == '0) begin
            r = ext;
        end else if (int'(shift) >= ACC_WIDTH) begin
            // Everything shifts out: only the sign survives, no rounding.
            r = acc[ACC_WIDTH-1] ? '1 : '0;
        end else begin
            half = (ACC_WIDTH + 1)'(1) << (shift - SHIFT_WIDTH'(1));
            r    = (ext + half) >>> shift;
        end
        sat = sat_signed(64'(r), OUT_WIDTH);
`ifdef PE_DRAIN_RELU_EN
        if (sat < 0)
            sat = '0;
`endif
        q = OUT_WIDTH'(sat);
    end

endmodule

// File: rtl/pe_acc_drain.sv
// Row accumulator drain: snapshots all PE lane accumulators while pulsing
// clear_acc, then streams the lanes requantized over valid/ready.
// Optional build macro PE_DRAIN_RELU_EN fuses a ReLU after saturation.
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready low, out_data/out_idx/out_last hold.
module pe_acc_drain
    import npu_pkg::*;
#(
    parameter int NUM_PE      = 8,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH = 5,
    localparam int IDX_W      = $clog2(NUM_PE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        drain_start,
    input  logic [SHIFT_WIDTH-1:0]      shift_amt,
    input  logic [NUM_PE*ACC_WIDTH-1:0] acc_in,
    input  logic [NUM_PE-1:0]           acc_valid_in,
    output logic                        clear_acc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    drain_state_t                state;
    logic [SHIFT_WIDTH-1:0]      shift_reg;
    logic signed [ACC_WIDTH-1:0] shadow [NUM_PE];
    logic [IDX_W-1:0]            lane_sel;
    logic signed [ACC_WIDTH-1:0] mux_val;
    logic signed [OUT_WIDTH-1:0] q;

    // Select the lane feeding the quantizer: lane 0 straight from the PEs while
    // the snapshot is being taken, otherwise the next shadow lane.
    always_comb begin
        lane_sel = out_idx + IDX_W'(1);
        mux_val  = shadow[lane_sel];
        if (state == CAPTURE) begin
            lane_sel = '0;
            mux_val  = acc_valid_in[0] ? acc_in[0 +: ACC_WIDTH] : '0;
        end
    end

    pe_requant #(
        .ACC_WIDTH   (ACC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc   (mux_val),
        .shift (shift_reg),
        .q     (q)
    );

    // Drain FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            clear_acc <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < NUM_PE; i++)
                shadow[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (drain_start) begin
                        state     <= CAPTURE;
                        shift_reg <= shift_amt;
                        clear_acc <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                CAPTURE: begin
                    // PEs clear on this same edge, so the snapshot is exact.
                    clear_acc <= 1'b0;
                    for (int i = 0; i < NUM_PE; i++)
                        shadow[i] <= acc_valid_in[i] ? acc_in[i*ACC_WIDTH +: ACC_WIDTH] : '0;
                    out_valid <= 1'b1;
                    out_idx   <= '0;
                    out_data  <= q;
                    out_last  <= (LAST_IDX == '0);
                    state     <= STREAM;
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (out_idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                            out_data  <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_idx  <= lane_sel;
                            out_data <= q;
                            out_last <= (lane_sel == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
